// File: rtl/core_dmem_resp_pkg.sv
// Shared memory-port widths, request bundle and sizing helper for the data-memory responder.
package core_dmem_resp_pkg;

  localparam int MEM_ADDR_W = 64;
  localparam int MEM_ADDR_R = MEM_ADDR_W - 1;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_DATA_R = MEM_DATA_W - 1;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;
  localparam int MEM_STRB_R = MEM_STRB_W - 1;

  typedef struct packed {
    logic [MEM_ADDR_R:0] addr;
    logic                wen;
    logic [MEM_STRB_R:0] strb;
    logic [MEM_DATA_R:0] wdata;
  } dmem_req_t;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

endpackage

// File: rtl/core_dmem_resp_ram.sv
// DEPTH x 64-bit word store: byte-enable synchronous write, registered read, contents never reset.
module core_dmem_resp_ram
  import core_dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_W-1:0]    idx,
  input  logic [MEM_STRB_R:0] strb,
  input  logic [MEM_DATA_R:0] wdata,
  output logic [MEM_DATA_R:0] rdata
);

  logic [MEM_DATA_R:0] mem_q [DEPTH];
  logic [MEM_DATA_R:0] rdata_q;

  // Byte-lane writes and the registered read share one index.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < MEM_STRB_W; b++) begin
        if (strb[b]) begin
          mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/core_dmem_resp.sv
// Data-memory responder: req/gnt handshake, range check, sticky protocol watchdog.
// CORE_DMEM_RESP_STALL_EN adds a WAIT state holding each access for WAIT_CYCLES.
module core_dmem_resp
  import core_dmem_resp_pkg::*;
#(
  parameter int unsigned         DEPTH       = 1024,
  parameter logic [MEM_ADDR_R:0] BASE        = 64'h0,
  parameter int unsigned         WAIT_CYCLES = 2
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                dmem_req,
  input  logic [MEM_ADDR_R:0] dmem_addr,
  input  logic                dmem_wen,
  input  logic [MEM_STRB_R:0] dmem_strb,
  input  logic [MEM_DATA_R:0] dmem_wdata,
  output logic                dmem_gnt,
  output logic                dmem_err,
  output logic [MEM_DATA_R:0] dmem_rdata,
  output logic                proto_err
);

  localparam int unsigned         IDX_W = idx_width(DEPTH);
  localparam logic [MEM_ADDR_R:0] SPAN  = MEM_ADDR_W'(DEPTH) << 3'd3;

`ifdef CORE_DMEM_RESP_STALL_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 32'd1) ? $clog2(WAIT_CYCLES + 32'd1) : 32'd1;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_e;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;
`endif

  state_e              state_q, state_d;
  dmem_req_t           req_q, req_d, in_s, acc_s;
  logic                gnt_q, gnt_d, err_q, err_d, rd_q, rd_d, proto_q, proto_d;
  logic                go_s, hit_s, ram_we_s, ram_re_s;
  logic [MEM_ADDR_R:0] off_s;
  logic [IDX_W-1:0]    idx_s;
  logic [MEM_DATA_R:0] ram_rdata_s;

  // The access being committed comes straight from the port in IDLE, else from the capture.
  assign in_s  = {dmem_addr, dmem_wen, dmem_strb, dmem_wdata};
  assign acc_s = (state_q == ST_IDLE) ? in_s : req_q;
  // Unsigned wrap makes addresses below BASE land far above SPAN.
  assign off_s = acc_s.addr - BASE;
  assign hit_s = (off_s < SPAN);
  assign idx_s = off_s[IDX_W+2:3];

  assign ram_we_s = go_s & acc_s.wen & hit_s & g_resetn;
  assign ram_re_s = go_s & ~acc_s.wen & hit_s;

  // Next-state, capture, response and watchdog logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    gnt_d   = 1'b0;
    err_d   = 1'b0;
    rd_d    = 1'b0;
    go_s    = 1'b0;
`ifdef CORE_DMEM_RESP_STALL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dmem_req) begin
          req_d = in_s;
`ifdef CORE_DMEM_RESP_STALL_EN
          if (WAIT_CYCLES != 32'd0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end else begin
            go_s = 1'b1;
          end
`else
          go_s = 1'b1;
`endif
        end else begin
          req_d = req_q;
        end
      end
`ifdef CORE_DMEM_RESP_STALL_EN
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1'b1);
        if (cnt_q == CNT_W'(1'b1)) begin
          go_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
`endif
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (go_s) begin
      state_d = ST_RESP;
      gnt_d   = 1'b1;
      err_d   = ~hit_s;
      rd_d    = hit_s & ~acc_s.wen;
    end else begin
      gnt_d   = 1'b0;
    end

    if ((state_q != ST_IDLE) && (!dmem_req || (in_s != req_q))) begin
      proto_d = 1'b1;
    end else begin
      proto_d = proto_q;
    end
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      proto_q <= proto_d;
    end
  end

`ifdef CORE_DMEM_RESP_STALL_EN
  // Stall counter register.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  core_dmem_resp_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (g_clk),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .idx   (idx_s),
    .strb  (acc_s.strb),
    .wdata (acc_s.wdata),
    .rdata (ram_rdata_s)
  );

  assign dmem_gnt   = gnt_q;
  assign dmem_err   = err_q;
  assign dmem_rdata = rd_q ? ram_rdata_s : '0;
  assign proto_err  = proto_q;

endmodule

// File: tb/tb_core_dmem_resp.sv
// Self-checking bench for core_dmem_resp against a word-array reference model.
// Define CORE_DMEM_RESP_STALL_EN for bench and RTL together to exercise the stall build.
module tb_core_dmem_resp;

  localparam int unsigned DEPTH       = 64;
  localparam logic [63:0] BASE        = 64'h0000_0000_8000_0000;
  localparam int unsigned WAIT_CYCLES = 2;
`ifdef CORE_DMEM_RESP_STALL_EN
  localparam int EXP_LAT = 1 + int'(WAIT_CYCLES);
`else
  localparam int EXP_LAT = 1;
`endif
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

  logic        clk = 1'b0;
  logic        g_resetn, dmem_req, dmem_wen, dmem_gnt, dmem_err, proto_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_strb;
  int          total = 0;
  int          bad   = 0;
  logic [63:0] model [DEPTH];

  always #5 clk = ~clk;

  core_dmem_resp #(
    .DEPTH       (DEPTH),
    .BASE        (BASE),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .g_clk      (clk),
    .g_resetn   (g_resetn),
    .dmem_req   (dmem_req),
    .dmem_addr  (dmem_addr),
    .dmem_wen   (dmem_wen),
    .dmem_strb  (dmem_strb),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_err   (dmem_err),
    .dmem_rdata (dmem_rdata),
    .proto_err  (proto_err)
  );

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + SPAN);
  endfunction

  function automatic logic [63:0] exp_read(input logic [63:0] a);
    if (!in_range(a)) return 64'd0;
    return model[int'((a - BASE) >> 3)];
  endfunction

  function automatic void model_write(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    int i;
    if (!in_range(a)) return;
    i = int'((a - BASE) >> 3);
    for (int b = 0; b < 8; b++) begin
      if (s[b]) model[i][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  // One complete handshake; quiet drops if err/rdata leak outside the grant or gnt lasts >1 cycle.
  task automatic access(input logic [63:0] a, input logic w, input logic [7:0] s, input logic [63:0] d,
                        output int lat, output logic e, output logic [63:0] r, output logic quiet);
    dmem_req = 1'b1; dmem_addr = a; dmem_wen = w; dmem_strb = s; dmem_wdata = d;
    lat = 0; e = 1'b0; r = 64'd0; quiet = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (dmem_gnt === 1'b1) begin
        lat = c; e = dmem_err; r = dmem_rdata;
        break;
      end else if (dmem_err !== 1'b0 || dmem_rdata !== 64'd0) begin
        quiet = 1'b0;
      end
    end
    @(posedge clk); #1;
    if (dmem_gnt !== 1'b0 || dmem_err !== 1'b0 || dmem_rdata !== 64'd0) quiet = 1'b0;
    dmem_req = 1'b0;
  endtask

  task automatic test_reset;
    g_resetn = 1'b0; dmem_req = 1'b0; dmem_addr = 64'd0; dmem_wen = 1'b0;
    dmem_strb = 8'd0; dmem_wdata = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (dmem_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0", dmem_gnt); end
    total++; if (dmem_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", dmem_err); end
    total++; if (dmem_rdata !== 64'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", dmem_rdata); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto: got %b want 0", proto_err); end
    g_resetn = 1'b1;
  endtask

  task automatic test_init;
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [63:0] a, d, r; logic e, q; int lat;
      a = BASE + 64'(8 * i);
      d = {$urandom, $urandom};
      access(a, 1'b1, 8'hFF, d, lat, e, r, q);
      model_write(a, 8'hFF, d);
      total++; if (lat != EXP_LAT) begin bad++; $display("FAIL init_lat[%0d]: got %0d want %0d", i, lat, EXP_LAT); end
      total++; if (e !== 1'b0 || r !== 64'd0) begin bad++; $display("FAIL init_resp[%0d]: got err=%b rdata=%h want 0/0", i, e, r); end
      total++; if (q !== 1'b1) begin bad++; $display("FAIL init_quiet[%0d]: got %b want 1", i, q); end
    end
  endtask

  task automatic test_directed;
    logic [63:0] r; logic e, q; int lat;
    access(BASE + 64'h10, 1'b1, 8'hFF, 64'h1122334455667788, lat, e, r, q);
    model_write(BASE + 64'h10, 8'hFF, 64'h1122334455667788);
    total++; if (lat != EXP_LAT || e !== 1'b0) begin bad++; $display("FAIL dir_wr_full: got lat=%0d err=%b want %0d/0", lat, e, EXP_LAT); end
    access(BASE + 64'h10, 1'b0, 8'h00, 64'd0, lat, e, r, q);
    total++; if (lat != EXP_LAT || e !== 1'b0) begin bad++; $display("FAIL dir_rd_lat: got lat=%0d err=%b want %0d/0", lat, e, EXP_LAT); end
    total++; if (r !== 64'h1122334455667788) begin bad++; $display("FAIL dir_rd_full: got %h want 1122334455667788", r); end
    access(BASE + 64'h10, 1'b1, 8'h0F, 64'hAAAAAAAABBBBBBBB, lat, e, r, q);
    model_write(BASE + 64'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB);
    access(BASE + 64'h13, 1'b0, 8'h00, 64'd0, lat, e, r, q);
    total++; if (r !== 64'h11223344BBBBBBBB || e !== 1'b0) begin bad++; $display("FAIL dir_rd_strb: got %h err=%b want 11223344bbbbbbbb/0", r, e); end
  endtask

  task automatic test_out_of_range;
    logic [63:0] r; logic e, q; int lat;
    access(BASE + SPAN, 1'b0, 8'h00, 64'd0, lat, e, r, q);
    total++; if (lat != EXP_LAT || e !== 1'b1 || r !== 64'd0) begin bad++; $display("FAIL oor_read: got lat=%0d err=%b rdata=%h want %0d/1/0", lat, e, r, EXP_LAT); end
    access(BASE + SPAN, 1'b1, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, lat, e, r, q);
    total++; if (e !== 1'b1 || r !== 64'd0) begin bad++; $display("FAIL oor_write: got err=%b rdata=%h want 1/0", e, r); end
    access(BASE - 64'd8, 1'b1, 8'hFF, 64'hCAFE_F00D_CAFE_F00D, lat, e, r, q);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL below_write: got err=%b want 1", e); end
    access(BASE + SPAN - 64'd8, 1'b0, 8'h00, 64'd0, lat, e, r, q);
    total++; if (e !== 1'b0 || r !== exp_read(BASE + SPAN - 64'd8)) begin bad++; $display("FAIL last_word: got %h err=%b want %h/0", r, e, exp_read(BASE + SPAN - 64'd8)); end
    access(BASE, 1'b0, 8'h00, 64'd0, lat, e, r, q);
    total++; if (r !== exp_read(BASE)) begin bad++; $display("FAIL word0_after_oor: got %h want %h", r, exp_read(BASE)); end
    access(BASE + SPAN - 64'd16, 1'b0, 8'h00, 64'd0, lat, e, r, q);
    total++; if (r !== exp_read(BASE + SPAN - 64'd16)) begin bad++; $display("FAIL below_alias: got %h want %h", r, exp_read(BASE + SPAN - 64'd16)); end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [63:0] a, d, r, er; logic w, e, q, ee; logic [7:0] s; int lat; int k;
      k = int'($urandom_range(0, 9));
      if (k == 0) a = BASE + SPAN + 64'(8 * $urandom_range(0, 3));
      else if (k == 1) a = BASE - 64'(8 * $urandom_range(1, 4));
      else a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1));
      a[2:0] = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      s = 8'($urandom);
      d = {$urandom, $urandom};
      ee = !in_range(a);
      er = w ? 64'd0 : exp_read(a);
      access(a, w, s, d, lat, e, r, q);
      if (w) model_write(a, s, d);
      total++; if (lat != EXP_LAT) begin bad++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, lat, EXP_LAT); end
      total++; if (e !== ee) begin bad++; $display("FAIL rnd_err[%0d]: addr=%h got %b want %b", i, a, e, ee); end
      total++; if (r !== er) begin bad++; $display("FAIL rnd_rdata[%0d]: addr=%h got %h want %h", i, a, r, er); end
      total++; if (q !== 1'b1) begin bad++; $display("FAIL rnd_quiet[%0d]: got %b want 1", i, q); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] ad [3]; logic wn [3]; logic [7:0] st [3]; logic [63:0] wd [3];
    logic [63:0] er [3]; logic [63:0] gr [3];
    int n, last, consec, badgap; logic prev;
    ad[0] = BASE + 64'(8 * $urandom_range(0, DEPTH - 1)); ad[1] = ad[0];
    ad[2] = BASE + 64'(8 * $urandom_range(0, DEPTH - 1));
    wn[0] = 1'b1; wn[1] = 1'b0; wn[2] = 1'b0;
    st[0] = 8'($urandom); st[1] = 8'h00; st[2] = 8'h00;
    wd[0] = {$urandom, $urandom}; wd[1] = 64'd0; wd[2] = 64'd0;
    er[0] = 64'd0;
    model_write(ad[0], st[0], wd[0]);
    er[1] = exp_read(ad[1]);
    er[2] = exp_read(ad[2]);
    n = 0; last = 0; consec = 0; badgap = 0; prev = 1'b0;
    dmem_req = 1'b1; dmem_addr = ad[0]; dmem_wen = wn[0]; dmem_strb = st[0]; dmem_wdata = wd[0];
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (dmem_gnt === 1'b1) begin
        if (prev) consec++;
        if (n < 3) gr[n] = dmem_rdata;
        if (n > 0 && (c - last) != EXP_LAT + 1) badgap++;
        last = c; n++;
      end else if (prev) begin
        if (n < 3) begin
          dmem_addr = ad[n]; dmem_wen = wn[n]; dmem_strb = st[n]; dmem_wdata = wd[n];
        end else begin
          dmem_req = 1'b0;
        end
      end
      prev = dmem_gnt;
    end
    dmem_req = 1'b0;
    total++; if (n != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", n); end
    total++; if (consec != 0) begin bad++; $display("FAIL b2b_pulse: got %0d adjacent grants want 0", consec); end
    total++; if (badgap != 0) begin bad++; $display("FAIL b2b_gap: got %0d wrong spacings want 0", badgap); end
    for (int i = 0; i < 3; i++) begin
      total++; if (n > i && gr[i] !== er[i]) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, gr[i], er[i]); end
    end
  endtask

  task automatic test_proto;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_clean: got %b want 0", proto_err); end
    for (int k = 0; k < 5; k++) begin
      logic [63:0] a, d, r; logic e, q, prev; int n, lat, rl;
      a = BASE + 64'(8 * (k + 3));
      d = {$urandom, $urandom};
      model_write(a, 8'hFF, d);
      dmem_req = 1'b1; dmem_addr = a; dmem_wen = 1'b1; dmem_strb = 8'hFF; dmem_wdata = d;
      n = 0; lat = 0; prev = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk); #1;
        if (c == 1) begin
          case (k)
            0: dmem_req = 1'b0;
            1: dmem_addr = a ^ 64'h8;
            2: dmem_wen = 1'b0;
            3: dmem_strb = 8'h0F;
            default: dmem_wdata = ~d;
          endcase
        end
        if (dmem_gnt === 1'b1) begin
          n++;
          if (lat == 0) lat = c;
        end else if (prev) begin
          dmem_req = 1'b0;
        end
        prev = dmem_gnt;
      end
      dmem_req = 1'b0;
      total++; if (n != 1 || lat != EXP_LAT) begin bad++; $display("FAIL proto_gnt[%0d]: got n=%0d lat=%0d want 1/%0d", k, n, lat, EXP_LAT); end
      total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_set[%0d]: got %b want 1", k, proto_err); end
      access(a, 1'b0, 8'h00, 64'd0, rl, e, r, q);
      total++; if (r !== exp_read(a)) begin bad++; $display("FAIL proto_commit[%0d]: got %h want %h", k, r, exp_read(a)); end
      total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky[%0d]: got %b want 1", k, proto_err); end
      g_resetn = 1'b0;
      @(posedge clk); #1;
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_clear[%0d]: got %b want 0", k, proto_err); end
      g_resetn = 1'b1;
    end
  endtask

  task automatic test_reset_inflight;
    logic [63:0] r; logic e, q; int lat, seen, dirty;
    access(BASE, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, lat, e, r, q);
    model_write(BASE, 8'hFF, 64'h0123_4567_89AB_CDEF);
    dmem_req = 1'b1; dmem_addr = BASE; dmem_wen = 1'b1; dmem_strb = 8'hFF; dmem_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef CORE_DMEM_RESP_STALL_EN
    @(posedge clk); #1;
`endif
    g_resetn = 1'b0;
    seen = 0; dirty = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (dmem_gnt !== 1'b0) seen++;
      if (dmem_err !== 1'b0 || dmem_rdata !== 64'd0 || proto_err !== 1'b0) dirty++;
    end
    dmem_req = 1'b0;
    g_resetn = 1'b1;
    @(posedge clk); #1;
    total++; if (seen != 0) begin bad++; $display("FAIL rst_nognt: got %0d grants want 0", seen); end
    total++; if (dirty != 0) begin bad++; $display("FAIL rst_outputs: got %0d nonzero cycles want 0", dirty); end
    access(BASE, 1'b0, 8'h00, 64'd0, lat, e, r, q);
    total++; if (r !== 64'h0123_4567_89AB_CDEF || lat != EXP_LAT) begin bad++; $display("FAIL rst_nowrite: got %h lat=%0d want 0123456789abcdef/%0d", r, lat, EXP_LAT); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_out_of_range();
    test_random(300);
    test_back_to_back();
    test_proto();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
